spi_bus_initiator: RTL and testbench
====================================

Name: spi_bus_initiator

Overview:
- Active SPI initiator. Generates SS, SCLK and MOSI from the system clock, and samples MISO.
- Provides the fake_sclk/fake_ss/fake_mosi drive path for frames that the MITM injects on its own, when no real master is present.
- Bus convention: SS idle low, asserted high for a frame; SCLK idle low; MOSI updated on SCLK fall; MISO sampled on SCLK rise; MSB first.
- One DATA_SIZE-bit full-duplex word per frame.

Parameters:
- DATA_SIZE, 8: bits per frame; minimum 2.
- CLK_DIV, 4: sys_clk cycles per SCLK half-period; minimum 1.
- SS_SETUP, 2: sys_clk cycles from SS assert to first SCLK rise; minimum 1.
- SS_HOLD, 2: sys_clk cycles from last SCLK fall to SS deassert; minimum 1.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- tx_data  in  DATA_SIZE  word to transmit; latched on accepted start.
- rx_data  out  DATA_SIZE  last received word; updated at frame end.
- busy  out  1  high from the cycle after an accepted start until frame end.
- done_sig  out  1  one-cycle pulse at frame end.
- sclk_out  out  1  generated SCLK.
- ss_out  out  1  generated SS, active high.
- mosi_out  out  1  generated MOSI.
- miso_in  in  1  MISO; caller provides synchronisation.

Behaviour:
Reset values (rst_n low, immediate and asynchronous):
- sclk_out=0, ss_out=0, mosi_out=0, busy=0, done_sig=0, rx_data=0.
- State IDLE; counters cleared.

States:
- IDLE:
  - start=1 latches tx_data into the tx shift register.
  - Next cycle: ss_out=1, mosi_out=tx_data[DATA_SIZE-1], busy=1, bit_cnt=0.
  - Go to SETUP.
- SETUP:
  - Wait SS_SETUP cycles.
  - Then sclk_out<=1 and shift miso_in into rx shift LSB in the same edge.
  - Go to HIGH.
- HIGH:
  - After CLK_DIV cycles, sclk_out<=0.
  - If bit_cnt==DATA_SIZE-1, go to HOLD; mosi_out holds the last bit.
  - Otherwise mosi_out<=next bit (same edge as the fall), go to LOW.
- LOW:
  - After CLK_DIV cycles, sclk_out<=1, sample miso_in, bit_cnt<=bit_cnt+1.
  - Go to HIGH.
- HOLD:
  - After SS_HOLD cycles: ss_out<=0, mosi_out<=0, busy<=0.
  - rx_data<=rx shift register; done_sig=1 for exactly that one cycle.
  - Go to IDLE.

Timing, with E0 = the edge that samples start:
- ss_out rises at E1.
- First SCLK rise at E1+SS_SETUP.
- Last SCLK fall at E1+SS_SETUP+(2*DATA_SIZE-1)*CLK_DIV.
- ss_out fall, busy fall and done_sig all occur SS_HOLD cycles after the last SCLK fall.
- Defaults: rises at E3, E11, …, E59; last fall E63; done at E65.
- Exactly DATA_SIZE rising edges per frame; SCLK period is 2*CLK_DIV.
- bit_cnt width is $clog2(DATA_SIZE); the division counter is sized for max(CLK_DIV, SS_SETUP, SS_HOLD).

Boundary conditions:
- start while not IDLE (including the done_sig cycle) is ignored; no queuing.
- start held high continuously: the next frame is accepted on the first IDLE cycle after done. The gap between frames is 1 cycle of ss_out low, plus the E0→E1 latency.
- tx_data changes after acceptance do not affect the current frame.
- rx_data is stable between done pulses and is never partially updated.
- Reset mid-frame: outputs go to reset values immediately. The truncated frame produces no done_sig, and rx_data=0.
- miso_in is sampled only at the SCLK-rise edges.

Test Plan:
- Loopback mosi_out→miso_in, tx_data=0xA5, defaults → exactly 8 SCLK rises; MOSI sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; done_sig single pulse at E65; busy high E1..E64.
- miso_in tied 1, tx_data=0x00 → mosi_out constant 0 throughout, rx_data=0xFF; SCLK high/low each 4 cycles; ss_out high E1–E64.
- start pulsed again at E20 and at the done cycle → both ignored; only one frame; ss_out stays low afterwards.
- start held high, tx_data=0x3C then 0xC3 → two back-to-back frames. ss_out low for the required gap. Looped back, rx_data=0x3C after the first done and 0xC3 after the second.
- rst_n low at E30 for 2 cycles → sclk_out/ss_out/busy drop asynchronously. No done_sig, rx_data=0. A new start afterwards completes normally with correct data.
- CLK_DIV=1, SS_SETUP=1, SS_HOLD=1, DATA_SIZE=16, loopback 0x8001 → SCLK toggles every cycle, 16 rises, rx_data=0x8001, done at E1+1+31+1.

Source files
------------

// File: rtl/spi_bus_initiator.sv
// SPI bus initiator: drives SS (active high), SCLK (idle low) and MOSI for one
// full-duplex DATA_SIZE-bit word per frame, MSB first. MOSI changes on SCLK fall,
// MISO is sampled on SCLK rise. Also serves as the drive path for self-injected frames.
module spi_bus_initiator #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned SS_SETUP  = 2,
    parameter int unsigned SS_HOLD   = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] tx_data,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic                 busy,
    output logic                 done_sig,
    output logic                 sclk_out,
    output logic                 ss_out,
    output logic                 mosi_out,
    input  logic                 miso_in
);

    localparam int unsigned MaxA   = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int unsigned MaxDiv = (MaxA > SS_HOLD) ? MaxA : SS_HOLD;
    localparam int unsigned CntW   = (MaxDiv > 1) ? $clog2(MaxDiv) : 1;
    localparam int unsigned BitW   = $clog2(DATA_SIZE);

    localparam logic [CntW-1:0] DivLast   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] SetupLast = CntW'(SS_SETUP - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(SS_HOLD - 1);
    localparam logic [BitW-1:0] BitLast   = BitW'(DATA_SIZE - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StSetup, StHigh, StLow, StHold} state_t;

    state_t                 state;
    logic [CntW-1:0]        div_cnt;
    logic [BitW-1:0]        bit_cnt;
    logic [DATA_SIZE-1:0]   tx_sh;
    logic [DATA_SIZE-1:0]   rx_sh;

    // Frame sequencer; every bus output is registered here.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done_sig <= 1'b0;
            sclk_out <= 1'b0;
            ss_out   <= 1'b0;
            mosi_out <= 1'b0;
        end else begin
            done_sig <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        tx_sh <= tx_data;
                        state <= StLoad;
                    end
                end
                // Assert SS one cycle after acceptance with the MSB already on MOSI.
                StLoad: begin
                    ss_out   <= 1'b1;
                    mosi_out <= tx_sh[DATA_SIZE-1];
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    rx_sh    <= '0;
                    state    <= StSetup;
                end
                StSetup: begin
                    if (div_cnt == SetupLast) begin
                        div_cnt  <= '0;
                        sclk_out <= 1'b1;
                        rx_sh    <= {rx_sh[DATA_SIZE-2:0], miso_in};
                        state    <= StHigh;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StHigh: begin
                    if (div_cnt == DivLast) begin
                        div_cnt  <= '0;
                        sclk_out <= 1'b0;
                        if (bit_cnt == BitLast) begin
                            // MOSI keeps the last bit until SS drops.
                            state <= StHold;
                        end else begin
                            tx_sh    <= {tx_sh[DATA_SIZE-2:0], 1'b0};
                            mosi_out <= tx_sh[DATA_SIZE-2];
                            state    <= StLow;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StLow: begin
                    if (div_cnt == DivLast) begin
                        div_cnt  <= '0;
                        sclk_out <= 1'b1;
                        rx_sh    <= {rx_sh[DATA_SIZE-2:0], miso_in};
                        bit_cnt  <= bit_cnt + 1'b1;
                        state    <= StHigh;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (div_cnt == HoldLast) begin
                        div_cnt  <= '0;
                        ss_out   <= 1'b0;
                        mosi_out <= 1'b0;
                        busy     <= 1'b0;
                        rx_data  <= rx_sh;
                        done_sig <= 1'b1;
                        state    <= StIdle;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_initiator.sv
// Scoreboard bench for spi_bus_initiator: a default-parameter instance and a
// fast 16-bit instance. Stimulus pushes expected frames; monitors pop on done_sig.
module tb_spi_bus_initiator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: defaults (8 bits, CLK_DIV 4, setup/hold 2).
    logic       start_a = 1'b0;
    logic [7:0] tx_a = 8'h00;
    logic [7:0] rx_a;
    logic       busy_a, done_a, sclk_a, ss_a, mosi_a, miso_a;
    logic       loop_a = 1'b1;
    assign miso_a = loop_a ? mosi_a : 1'b1;

    spi_bus_initiator dut_a (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .start   (start_a),
        .tx_data (tx_a),
        .rx_data (rx_a),
        .busy    (busy_a),
        .done_sig(done_a),
        .sclk_out(sclk_a),
        .ss_out  (ss_a),
        .mosi_out(mosi_a),
        .miso_in (miso_a)
    );

    // Instance B: 16 bits, everything at minimum timing, always looped back.
    logic        start_b = 1'b0;
    logic [15:0] tx_b = 16'h0000;
    logic [15:0] rx_b;
    logic        busy_b, done_b, sclk_b, ss_b, mosi_b;

    spi_bus_initiator #(
        .DATA_SIZE(16),
        .CLK_DIV  (1),
        .SS_SETUP (1),
        .SS_HOLD  (1)
    ) dut_b (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .start   (start_b),
        .tx_data (tx_b),
        .rx_data (rx_b),
        .busy    (busy_b),
        .done_sig(done_b),
        .sclk_out(sclk_b),
        .ss_out  (ss_b),
        .mosi_out(mosi_b),
        .miso_in (mosi_b)
    );

    typedef struct {
        logic [15:0] rx;
        logic [15:0] mosi;
        int          done_cyc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor A: SCLK phase lengths, MOSI bit sequence, frame result on done.
    initial begin
        int         rises = 0;
        int         hi = 0;
        int         lo = 0;
        logic [7:0] mseq = '0;
        logic       prev_sclk = 1'b0;
        logic       prev_ss = 1'b0;
        logic       chk_low = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rises = 0; hi = 0; lo = 0; chk_low = 1'b0;
            end else begin
                if (chk_low) begin
                    check("a_done_one_cycle", done_a, 0);
                    chk_low = 1'b0;
                end
                if (ss_a && !prev_ss) begin
                    rises = 0;
                    mseq  = '0;
                end
                if (sclk_a && !prev_sclk) begin
                    if (rises > 0) check("a_sclk_low_len", lo, 4);
                    hi    = 1;
                    rises++;
                    mseq  = {mseq[6:0], mosi_a};
                end else if (sclk_a) begin
                    hi++;
                end else if (prev_sclk) begin
                    check("a_sclk_high_len", hi, 4);
                    lo = 1;
                end else begin
                    lo++;
                end
                if (done_a) begin
                    if (sb_a.size() == 0) begin
                        flag_fail("a_unexpected_done");
                    end else begin
                        e = sb_a.pop_front();
                        check("a_rx_data", rx_a, e.rx[7:0]);
                        check("a_mosi_seq", mseq, e.mosi[7:0]);
                        check("a_done_cycle", cyc, e.done_cyc);
                        check("a_sclk_rises", rises, 8);
                        check("a_busy_at_done", busy_a, 0);
                        check("a_ss_at_done", ss_a, 0);
                    end
                    chk_low = 1'b1;
                end
            end
            prev_sclk = sclk_a;
            prev_ss   = ss_a;
        end
    end

    // Monitor B: rise count, MOSI sequence and result on done.
    initial begin
        int          rises = 0;
        logic [15:0] mseq = '0;
        logic        prev_sclk = 1'b0;
        logic        prev_ss = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ss_b && !prev_ss) begin
                    rises = 0;
                    mseq  = '0;
                end
                if (sclk_b && !prev_sclk) begin
                    rises++;
                    mseq = {mseq[14:0], mosi_b};
                end
                if (done_b) begin
                    if (sb_b.size() == 0) begin
                        flag_fail("b_unexpected_done");
                    end else begin
                        e = sb_b.pop_front();
                        check("b_rx_data", rx_b, e.rx);
                        check("b_mosi_seq", mseq, e.mosi);
                        check("b_done_cycle", cyc, e.done_cyc);
                        check("b_sclk_rises", rises, 16);
                    end
                end
            end
            prev_sclk = sclk_b;
            prev_ss   = ss_b;
        end
    end

    int e0;

    // Drives start for one cycle; E0 is the next rising edge. Returns after E0.
    task automatic frame_a(input logic [7:0] tx, input logic [7:0] exp_rx,
                           input logic [7:0] exp_mosi);
        exp_t e;
        @(negedge clk);
        start_a = 1'b1;
        tx_a    = tx;
        e0      = cyc + 1;
        e.rx = {8'h00, exp_rx}; e.mosi = {8'h00, exp_mosi}; e.done_cyc = e0 + 65;
        sb_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        tx_a    = ~tx;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0 || busy_a || busy_b) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) flag_fail("timeout_waiting_for_done");
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        exp_t eb;
        // Reset values.
        #1;
        check("rst_sclk", sclk_a, 0);
        check("rst_ss", ss_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rx", rx_a, 8'h00);
        check("rst_b_rx", rx_b, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Loopback 0xA5.
        loop_a = 1'b1;
        frame_a(8'hA5, 8'hA5, 8'hA5);
        wait_idle(200);

        // MISO tied high, all-zero transmit.
        loop_a = 1'b0;
        frame_a(8'h00, 8'hFF, 8'h00);
        wait_idle(200);
        loop_a = 1'b1;

        // Extra starts at E20 and at the done edge E65 must be ignored.
        frame_a(8'h96, 8'h96, 8'h96);
        wait_cyc(e0 + 19);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(e0 + 64);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle(200);
        repeat (10) @(negedge clk);
        check("ignored_start_ss_low", ss_a, 0);
        check("ignored_start_busy_low", busy_a, 0);

        // Start held high: back-to-back frames 0x3C then 0xC3.
        @(negedge clk);
        start_a = 1'b1;
        tx_a    = 8'h3C;
        e0      = cyc + 1;
        eb.rx = 16'h003C; eb.mosi = 16'h003C; eb.done_cyc = e0 + 65;
        sb_a.push_back(eb);
        eb.rx = 16'h00C3; eb.mosi = 16'h00C3; eb.done_cyc = e0 + 66 + 65;
        sb_a.push_back(eb);
        @(negedge clk);
        tx_a = 8'hC3;
        wait_cyc(e0 + 65);
        check("b2b_gap_ss_e65", ss_a, 0);
        @(negedge clk);
        check("b2b_gap_ss_e66", ss_a, 0);
        start_a = 1'b0;
        tx_a    = 8'h00;
        @(negedge clk);
        check("b2b_ss_e67", ss_a, 1);
        wait_idle(300);

        // Reset asserted mid-frame at E30 for two cycles.
        frame_a(8'h77, 8'h77, 8'h77);
        wait_cyc(e0 + 29);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_sclk", sclk_a, 0);
        check("midrst_ss", ss_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_mosi", mosi_a, 0);
        sb_a.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("midrst_rx_zero", rx_a, 8'h00);
        check("midrst_ss_idle", ss_a, 0);

        // Normal frame after the reset.
        frame_a(8'h5A, 8'h5A, 8'h5A);
        wait_idle(200);

        // Instance B: 16-bit loopback 0x8001, done 34 cycles after E0.
        @(negedge clk);
        start_b = 1'b1;
        tx_b    = 16'h8001;
        e0      = cyc + 1;
        eb.rx = 16'h8001; eb.mosi = 16'h8001; eb.done_cyc = e0 + 34;
        sb_b.push_back(eb);
        @(negedge clk);
        start_b = 1'b0;
        tx_b    = 16'h0000;
        wait_idle(200);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
